// File: rtl/product_accumulator_if.sv
// Term/group stream bundle between the array multiplier, product_accumulator and its consumer.
interface product_accumulator_if #(
   parameter int ACC_W = 10,
   parameter int CNT_W = 4
);
   logic [5:0]       p_in;
   logic             in_valid;
   logic             in_last;
   logic             in_ready;
   logic [ACC_W-1:0] sum;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output p_in, in_valid, in_last, out_ready,
      input  in_ready, sum, count, overflow, out_valid
   );

   modport slave (
      input  p_in, in_valid, in_last, out_ready,
      output in_ready, sum, count, overflow, out_valid
   );
endinterface

// File: rtl/product_accumulator.sv
// Accumulates up to MAX_TERMS 6-bit products per group and holds the group sum until delivered.
// Define PRODUCT_ACC_SATURATE_EN to clamp the sum at all ones on carry instead of wrapping.
module product_accumulator #(
   parameter int ACC_W     = 10,
   parameter int MAX_TERMS = 8,
   parameter int CNT_W     = 4
) (
   input logic                clk,
   input logic                rst_n,
   product_accumulator_if.slave bus
);
   typedef enum logic {ACCUM, HOLD} state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;
   logic [ACC_W:0]   sum_ext;
   logic             carry;
   logic             close;

   always_comb begin
      sum_ext = {1'b0, acc} + (ACC_W+1)'(bus.p_in);
      carry   = sum_ext[ACC_W];
      close   = bus.in_last || (cnt == CNT_W'(MAX_TERMS - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACCUM;
         acc   <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (bus.in_valid) begin
`ifdef PRODUCT_ACC_SATURATE_EN
                  // Once clamped, any further nonzero term carries again, so the clamp sticks.
                  acc <= carry ? '1 : sum_ext[ACC_W-1:0];
`else
                  acc <= sum_ext[ACC_W-1:0];
`endif
                  cnt <= cnt + CNT_W'(1);
                  ovf <= ovf | carry;
                  if (close) state <= HOLD;
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  acc   <= '0;
                  cnt   <= '0;
                  ovf   <= 1'b0;
                  state <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

   assign bus.in_ready  = (state == ACCUM);
   assign bus.out_valid = (state == HOLD);
   assign bus.sum       = acc;
   assign bus.count     = cnt;
   assign bus.overflow  = ovf;
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator with a group scoreboard; a second ACC_W=8 instance covers overflow.
module tb_product_accumulator;
   localparam int ACC_W     = 10;
   localparam int MAX_TERMS = 8;
   localparam int CNT_W     = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   product_accumulator_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) a ();
   product_accumulator_if #(.ACC_W(8), .CNT_W(CNT_W)) b ();

   product_accumulator #(.ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(a.slave)
   );
   product_accumulator #(.ACC_W(8), .MAX_TERMS(MAX_TERMS), .CNT_W(CNT_W)) dut8 (
      .clk(clk), .rst_n(rst_n), .bus(b.slave)
   );

   typedef struct {
      int unsigned sum;
      int unsigned cnt;
      bit          ovf;
   } exp_t;

   exp_t        sb[$];
   int unsigned m_acc, m_cnt;
   bit          m_ovf;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic void model_clear();
      m_acc = 0;
      m_cnt = 0;
      m_ovf = 1'b0;
   endfunction

   function automatic void model_add(input int unsigned p, input int unsigned w);
      int unsigned s;
      s = m_acc + p;
      if (s >= (32'd1 << w)) begin
         m_ovf = 1'b1;
`ifdef PRODUCT_ACC_SATURATE_EN
         s = (32'd1 << w) - 1;
`else
         s = s - (32'd1 << w);
`endif
      end
      m_acc = s;
      m_cnt++;
   endfunction

   task automatic push_term(input int unsigned p, input bit last);
      int  n;
      bit  closed;
      n = 0;
      @(negedge clk);
      while (a.in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n == 20) check("in_ready_timeout", {31'd0, a.in_ready}, 32'd1);
      a.p_in     = 6'(p);
      a.in_valid = 1'b1;
      a.in_last  = last;
      model_add(p, ACC_W);
      closed = last || (m_cnt == MAX_TERMS);
      @(posedge clk);
      #1;
      check("acc_sum", a.sum, m_acc);
      check("acc_count", a.count, m_cnt);
      check("close_valid", {31'd0, a.out_valid}, {31'd0, closed});
      check("close_ready", {31'd0, a.in_ready}, {31'd0, !closed});
      if (closed) sb.push_back('{sum: m_acc, cnt: m_cnt, ovf: m_ovf});
      a.in_valid = 1'b0;
      a.in_last  = 1'b0;
   endtask

   task automatic deliver(input int hold, input bit offer);
      exp_t e;
      check("sb_nonempty", sb.size() > 0, 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         a.in_valid  = offer;
         a.p_in      = 6'd63;
         a.in_last   = 1'b0;
         a.out_ready = 1'b0;
         repeat (hold) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'd0, a.out_valid}, 32'd1);
            check("hold_ready", {31'd0, a.in_ready}, 32'd0);
            check("hold_sum", a.sum, e.sum);
            check("hold_count", a.count, e.cnt);
         end
         a.out_ready = 1'b1;
         check("dlv_sum", a.sum, e.sum);
         check("dlv_count", a.count, e.cnt);
         check("dlv_ovf", {31'd0, a.overflow}, {31'd0, e.ovf});
         @(posedge clk);
         #1;
         check("post_valid", {31'd0, a.out_valid}, 32'd0);
         check("post_ready", {31'd0, a.in_ready}, 32'd1);
         check("post_sum", a.sum, 32'd0);
         check("post_count", a.count, 32'd0);
         a.out_ready = 1'b0;
         a.in_valid  = 1'b0;
      end
      model_clear();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      a.p_in = '0; a.in_valid = 1'b0; a.in_last = 1'b0; a.out_ready = 1'b0;
      b.p_in = '0; b.in_valid = 1'b0; b.in_last = 1'b0; b.out_ready = 1'b0;
      model_clear();

      // reset values, with in_valid asserted to show it is ignored
      a.in_valid = 1'b1;
      a.p_in     = 6'd9;
      repeat (2) @(posedge clk);
      #1;
      check("rst_sum", a.sum, 32'd0);
      check("rst_count", a.count, 32'd0);
      check("rst_ovf", {31'd0, a.overflow}, 32'd0);
      check("rst_valid", {31'd0, a.out_valid}, 32'd0);
      check("rst_ready", {31'd0, a.in_ready}, 32'd1);
      a.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // basic three-term group, out_ready high straight away
      push_term(6, 0);
      push_term(12, 0);
      push_term(49, 1);
      check("basic_sum", a.sum, 32'd67);
      deliver(0, 0);

      // auto-close at MAX_TERMS, ninth term held off
      for (int k = 0; k < 8; k++) push_term(49, 0);
      check("auto_sum", a.sum, 32'd392);
      check("auto_count", a.count, 32'd8);
      deliver(2, 1);

      // long hold with input pressure, then a fresh group from zero
      push_term(5, 0);
      push_term(7, 1);
      deliver(4, 1);
      push_term(3, 1);
      check("fresh_sum", a.sum, 32'd3);
      deliver(0, 0);

      // narrow accumulator overflow on the ACC_W=8 instance
      @(negedge clk);
      b.p_in     = 6'd49;
      b.in_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         b.in_last = (k == 5);
         @(posedge clk);
         #1;
      end
      b.in_valid = 1'b0;
      b.in_last  = 1'b0;
      check("ovf_valid", {31'd0, b.out_valid}, 32'd1);
      check("ovf_count", b.count, 32'd6);
      check("ovf_flag", {31'd0, b.overflow}, 32'd1);
`ifdef PRODUCT_ACC_SATURATE_EN
      check("ovf_sum", b.sum, 32'd255);
`else
      check("ovf_sum", b.sum, 32'd38);
`endif
      b.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("ovf_post_valid", {31'd0, b.out_valid}, 32'd0);
      check("ovf_post_flag", {31'd0, b.overflow}, 32'd0);
      b.out_ready = 1'b0;

      // asynchronous reset mid-group
      push_term(1, 0);
      push_term(2, 0);
      push_term(3, 0);
      @(negedge clk);
      a.in_valid = 1'b1;
      a.p_in     = 6'd5;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_sum", a.sum, 32'd0);
      check("arst_count", a.count, 32'd0);
      check("arst_valid", {31'd0, a.out_valid}, 32'd0);
      check("arst_ready", {31'd0, a.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      check("arst_hold_sum", a.sum, 32'd0);
      @(negedge clk);
      rst_n      = 1'b1;
      a.in_valid = 1'b0;
      model_clear();
      push_term(1, 1);
      check("arst_one_count", a.count, 32'd1);
      deliver(0, 0);

      // all 64 products i*j, grouped by i
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) push_term(i * j, j == 7);
         check("dot_sum", a.sum, 28 * i);
         deliver(0, 0);
      end

      check("sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
